tnn_neuron_accum: RTL and testbench

TNN_NEURON_ACCUM -- requirements
Module: tnn_neuron_accum

---
 rtl/tnn_neuron_accum.sv | 110 +++++++++++
 tb/tb_tnn_neuron_accum.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_neuron_accum.sv
// Ternary-network neuron accumulator: sums (pos_cnt - neg_cnt) over a beat stream and emits a ternary activation.
// Optional build macro TNN_ACC_SAT_EN selects a saturating accumulator instead of the default wrapping one.
module tnn_neuron_accum #(
    parameter int ACC_W = 10,
    parameter int TH_HI = 4,
    parameter int TH_LO = -4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       pos_cnt,
    input  logic [4:0]       neg_cnt,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_act,
    output logic [ACC_W-1:0] out_sum
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic signed [ACC_W-1:0] TH_HI_W = ACC_W'(TH_HI);
    localparam logic signed [ACC_W-1:0] TH_LO_W = ACC_W'(TH_LO);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] next_acc;
    logic signed [5:0]       delta;
    logic [1:0]              next_act;
    logic                    beat_fire;
    logic                    out_fire;
`ifdef TNN_ACC_SAT_EN
    logic [ACC_W:0]          sum_ext;
`endif

    assign beat_fire = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        delta    = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
        base     = (state == IDLE) ? '0 : acc;
        next_acc = '0;
        next_act = 2'b00;
`ifdef TNN_ACC_SAT_EN
        // One guard bit exposes overflow; clamp to the rail in the direction of travel.
        sum_ext = {base[ACC_W-1], base} + {{(ACC_W-5){delta[5]}}, delta};
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1])
            next_acc = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            next_acc = sum_ext[ACC_W-1:0];
`else
        next_acc = base + {{(ACC_W-6){delta[5]}}, delta};
`endif
        if (next_acc > TH_HI_W)
            next_act = 2'b01;
        else if (next_acc < TH_LO_W)
            next_act = 2'b11;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_act   <= 2'b00;
            out_sum   <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat_fire) begin
                        acc <= next_acc;
                        if (in_last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= next_acc;
                            out_act   <= next_act;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    // Result and handshake outputs hold until downstream takes the result.
                    if (out_fire) begin
                        state     <= IDLE;
                        acc       <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tnn_neuron_accum.sv
// Scoreboard bench for tnn_neuron_accum: directed vectors plus a modelled random stream with stalls.
`timescale 1ns/1ps
module tb_tnn_neuron_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] pos_cnt = '0;
    logic [4:0] neg_cnt = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_act;
    logic [9:0] out_sum;

    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [4:0] b_pos = '0;
    logic [4:0] b_neg = '0;
    logic       b_last = 1'b0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic [1:0] b_out_act;
    logic [6:0] b_out_sum;

    always #5 clk = ~clk;

    tnn_neuron_accum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_sum(out_sum)
    );

    tnn_neuron_accum #(.ACC_W(7)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pos_cnt(b_pos), .neg_cnt(b_neg), .in_last(b_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_act(b_out_act), .out_sum(b_out_sum)
    );

    typedef struct {
        int sum;
        int act;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   received = 0;
    bit   rand_mode = 0;
    bit   watch = 0;
    bit   saw_valid = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic push(input int sum, input int act);
        exp_t x;
        x.sum = sum;
        x.act = act;
        sb.push_back(x);
        pushed++;
    endtask

    // Inputs change only here, 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input int p, input int n, input bit l);
        bit accepted;
        accepted = 0;
        in_valid = 1'b1;
        pos_cnt  = 5'(p);
        neg_cnt  = 5'(n);
        in_last  = l;
        for (int k = 0; k < 100 && !accepted; k++) begin
            @(negedge clk);
            accepted = in_ready;
            tick();
        end
        check("beat_accepted", int'(accepted), 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
        check("scoreboard_drained", sb.size(), 0);
    endtask

    function automatic int fit(input int v, input int w);
`ifdef TNN_ACC_SAT_EN
        if (v > (1 << (w - 1)) - 1) return (1 << (w - 1)) - 1;
        if (v < -(1 << (w - 1))) return -(1 << (w - 1));
        return v;
`else
        int r;
        r = v & ((1 << w) - 1);
        if (r >= (1 << (w - 1))) r -= (1 << w);
        return r;
`endif
    endfunction

    function automatic int act_of(input int s);
        if (s > 4) return 1;
        if (s < -4) return 3;
        return 0;
    endfunction

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", int'(out_valid), 0);
            end else begin
                e = sb.pop_front();
                check("out_sum", int'($signed(out_sum)), e.sum);
                check("out_act", int'(out_act), e.act);
                received++;
            end
        end
        if (watch && out_valid) saw_valid = 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p, n, d, m_acc;
        bit l, m_idle;

        // Reset state
        tick();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_act", int'(out_act), 0);
        check("rst_out_sum", int'(out_sum), 0);
        tick();
        rst = 1'b0;

        // Three-beat neuron: 7 + 5 - 7 = 5 -> +1
        push(5, 1);
        send_beat(10, 3, 0);
        send_beat(7, 2, 0);
        check("no_early_valid", int'(out_valid), 0);
        send_beat(1, 8, 1);
        check("latency_valid", int'(out_valid), 1);
        wait_drain();

        // Single-beat neurons around the lower threshold
        push(0, 0);
        send_beat(4, 4, 1);
        push(-4, 0);
        send_beat(2, 6, 1);
        push(-5, 3);
        send_beat(2, 7, 1);
        wait_drain();

        // Backpressure: result 6 held, stalled beat must not be consumed
        out_ready = 1'b0;
        push(6, 1);
        send_beat(9, 3, 1);
        in_valid = 1'b1;
        pos_cnt  = 5'd3;
        neg_cnt  = 5'd0;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_out_sum", int'($signed(out_sum)), 6);
            check("stall_out_act", int'(out_act), 1);
        end
        tick();
        push(3, 0);
        out_ready = 1'b1;
        tick();
        check("post_hs_in_ready", int'(in_ready), 1);
        check("post_hs_out_valid", int'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        wait_drain();

        // Narrow accumulator overflow: 4 x 31 = 124
        b_in_valid = 1'b1;
        b_pos = 5'd31;
        b_neg = 5'd0;
        for (int i = 0; i < 4; i++) begin
            b_last = (i == 3);
            check("b_in_ready", int'(b_in_ready), 1);
            tick();
        end
        b_in_valid = 1'b0;
        b_last = 1'b0;
        check("b_out_valid", int'(b_out_valid), 1);
`ifdef TNN_ACC_SAT_EN
        check("b_out_sum", int'($signed(b_out_sum)), 63);
        check("b_out_act", int'(b_out_act), 1);
`else
        check("b_out_sum", int'($signed(b_out_sum)), -4);
        check("b_out_act", int'(b_out_act), 0);
`endif
        b_out_ready = 1'b1;
        tick();
        check("b_out_valid_clr", int'(b_out_valid), 0);
        b_out_ready = 1'b0;

        // Reset mid-neuron discards the partial sum
        send_beat(20, 0, 0);
        send_beat(20, 0, 0);
        rst = 1'b1;
        saw_valid = 0;
        watch = 1;
        tick();
        rst = 1'b0;
        push(1, 0);
        send_beat(1, 0, 1);
        watch = 0;
        check("no_valid_after_rst", int'(saw_valid), 0);
        wait_drain();

        // Random stream against the reference model
        m_idle = 1;
        m_acc = 0;
        rand_mode = 1;
        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(0, 31);
            n = $urandom_range(0, 31);
            l = (i == 39) || ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) tick();
            send_beat(p, n, l);
            d = p - n;
            m_acc = fit(m_idle ? d : m_acc + d, 10);
            m_idle = l;
            if (l) push(m_acc, act_of(m_acc));
        end
        rand_mode = 0;
        out_ready = 1'b1;
        wait_drain();
        check("results_count", received, pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
